// File: rtl/glitch_filter_pkg.sv
// Shared FSM encoding, default constants and a clog2 helper for the glitch filter.
// Constants here are defaults only; the top exposes them as overridable parameters.
package glitch_filter_pkg;

  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_CHK_HI = 2'd1,
    S_HI     = 2'd2,
    S_CHK_LO = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STABLE_CYC  = 4;
  localparam int DEF_CNT_W       = 8;

  // Smallest r with 2**r >= value; returns at least 1 so a counter is never zero-width.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/glitch_filter_ch.sv
// One channel: synchroniser, stability FSM with registered level/strobes, optional glitch counter.
// Latency SYNC_STAGES+STABLE_CYC edges from a stable input to dout; no backpressure, runs every cycle.
module glitch_filter_ch
  import glitch_filter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CYC  = DEF_STABLE_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             din,
  input  logic             cnt_clr,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int SC_W = clog2(STABLE_CYC);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYC - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [SC_W-1:0]        r_sc;
  logic                   r_dout;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;
  logic                   w_glitch;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // A check aborted by the opposite level is exactly one rejected pulse.
  assign w_glitch = ((r_state == S_CHK_HI) && !w_s) ||
                    ((r_state == S_CHK_LO) &&  w_s);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_LO;
      r_sc    <= '0;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        S_LO: begin
          if (w_s) begin
            r_state <= S_CHK_HI;
            r_sc    <= SC_W'(1);
          end
        end
        S_CHK_HI: begin
          if (!w_s) begin
            r_state <= S_LO;
          end else if (r_sc == SC_LAST) begin
            r_state <= S_HI;
            r_dout  <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_sc <= r_sc + SC_W'(1);
          end
        end
        S_HI: begin
          if (!w_s) begin
            r_state <= S_CHK_LO;
            r_sc    <= SC_W'(1);
          end
        end
        S_CHK_LO: begin
          if (w_s) begin
            r_state <= S_HI;
          end else if (r_sc == SC_LAST) begin
            r_state <= S_LO;
            r_dout  <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_sc <= r_sc + SC_W'(1);
          end
        end
        default: begin
          r_state <= S_LO;
        end
      endcase
    end
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;

`ifdef GLITCH_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_glitch && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign glitch_cnt = r_cnt;
`else
  logic w_unused;

  assign w_unused   = cnt_clr | w_glitch;
  assign glitch_cnt = '0;
`endif

endmodule

// File: rtl/glitch_filter.sv
// N_CH independent glitch filters; glitch counters exist only when GLITCH_CNT_EN is defined.
// Latency SYNC_STAGES+STABLE_CYC edges per channel; no backpressure, every cycle is consumed.
module glitch_filter
  import glitch_filter_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int STABLE_CYC  = DEF_STABLE_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [N_CH-1:0]       din,
  input  logic                  cnt_clr,
  output logic [N_CH-1:0]       dout,
  output logic [N_CH-1:0]       rise,
  output logic [N_CH-1:0]       fall,
  output logic [N_CH*CNT_W-1:0] glitch_cnt
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    glitch_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_CYC  (STABLE_CYC),
      .CNT_W       (CNT_W)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .din        (din[i]),
      .cnt_clr    (cnt_clr),
      .dout       (dout[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .glitch_cnt (glitch_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_glitch_filter.sv
// Directed scenarios plus random traffic, checked every cycle against a run-length reference model.
module tb_glitch_filter;

  localparam int N_CH   = 2;
  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef GLITCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                  sys_clk = 1'b0;
  logic                  sys_rst;
  logic                  cnt_clr;
  logic [N_CH-1:0]       din;
  logic [N_CH-1:0]       dout;
  logic [N_CH-1:0]       rise;
  logic [N_CH-1:0]       fall;
  logic [N_CH*CNT_W-1:0] glitch_cnt;

  always #5 sys_clk = ~sys_clk;

  glitch_filter #(
    .N_CH        (N_CH),
    .SYNC_STAGES (SYNC),
    .STABLE_CYC  (STABLE),
    .CNT_W       (CNT_W)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .din        (din),
    .cnt_clr    (cnt_clr),
    .dout       (dout),
    .rise       (rise),
    .fall       (fall),
    .glitch_cnt (glitch_cnt)
  );

  // Reference model: input seen SYNC edges late, level accepted after STABLE equal samples.
  bit              m_hist [N_CH][SYNC];
  bit              m_lvl  [N_CH];
  int              m_run  [N_CH];
  int              m_cnt  [N_CH];
  logic [N_CH-1:0] m_rise;
  logic [N_CH-1:0] m_fall;

  int n_pass = 0;
  int n_chk  = 0;
  int rises;
  int falls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      for (int k = 0; k < SYNC; k++) m_hist[c][k] = 1'b0;
      m_lvl[c] = 1'b0;
      m_run[c] = 0;
      m_cnt[c] = 0;
    end
    m_rise = '0;
    m_fall = '0;
  endtask

  task automatic model_edge();
    if (sys_rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N_CH; c++) begin
      bit s;
      bit g;
      s = m_hist[c][SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
      m_hist[c][0] = din[c];
      g = 1'b0;
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (s != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == STABLE) begin
          m_lvl[c]  = s;
          m_rise[c] = s;
          m_fall[c] = !s;
          m_run[c]  = 0;
        end
      end else begin
        g = (m_run[c] > 0);
        m_run[c] = 0;
      end
      if (cnt_clr) m_cnt[c] = 0;
      else if (g && m_cnt[c] < CNT_MAX) m_cnt[c]++;
    end
  endtask

  function automatic logic [N_CH*CNT_W-1:0] exp_cnt();
    logic [N_CH*CNT_W-1:0] v;
    v = '0;
    if (CNT_EN) begin
      for (int c = 0; c < N_CH; c++) v[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
    end
    return v;
  endfunction

  task automatic tick();
    logic [N_CH-1:0] lv;
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
    for (int c = 0; c < N_CH; c++) lv[c] = m_lvl[c];
    chk("dout", 32'(dout), 32'(lv));
    chk("rise", 32'(rise), 32'(m_rise));
    chk("fall", 32'(fall), 32'(m_fall));
    chk("glitch_cnt", 32'(glitch_cnt), 32'(exp_cnt()));
    if (rise[0]) rises++;
    if (fall[0]) falls++;
  endtask

  initial begin
    sys_rst = 1'b1;
    cnt_clr = 1'b0;
    din     = 2'b11;
    rises   = 0;
    falls   = 0;
    model_reset();

    // 1: reset state, then 6-edge latency to a clean high.
    repeat (3) tick();
    chk("t1_rst_dout", 32'(dout), 32'h0);
    chk("t1_rst_strobes", 32'({rise, fall}), 32'h0);
    chk("t1_rst_cnt", 32'(glitch_cnt), 32'h0);
    sys_rst = 1'b0;
    repeat (5) tick();
    chk("t1_dout_e5", 32'(dout), 32'h0);
    tick();
    chk("t1_dout_e6", 32'(dout), 32'h3);
    chk("t1_rise_e6", 32'(rise), 32'h3);
    tick();
    chk("t1_rise_e7", 32'(rise), 32'h0);
    chk("t1_dout_e7", 32'(dout), 32'h3);

    // 2: 3-clock pulse on ch0 is rejected and counted once.
    din = 2'b10;
    repeat (10) tick();
    chk("t2_pre_dout", 32'(dout), 32'h2);
    din[0] = 1'b1;
    repeat (3) tick();
    din[0] = 1'b0;
    repeat (10) tick();
    chk("t2_dout0", 32'(dout[0]), 32'h0);
    chk("t2_cnt0", 32'(glitch_cnt[7:0]), CNT_EN ? 32'd1 : 32'd0);
    chk("t2_cnt1", 32'(glitch_cnt[15:8]), 32'h0);
    chk("t2_dout1", 32'(dout[1]), 32'h1);

    // 3: 4-clock pulse is accepted, then falls cleanly.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    rises = 0;
    falls = 0;
    for (int i = 0; i < 16; i++) begin
      din[0] = (i < 4);
      tick();
    end
    chk("t3_rises", 32'(rises), 32'd1);
    chk("t3_falls", 32'(falls), 32'd1);
    chk("t3_dout0", 32'(dout[0]), 32'h0);
    chk("t3_cnt0", 32'(glitch_cnt[7:0]), 32'h0);

    // 4: 300 single-cycle pulses saturate ch1, then clear.
    din = 2'b00;
    repeat (10) tick();
    repeat (300) begin
      din[1] = 1'b1;
      tick();
      din[1] = 1'b0;
      tick();
    end
    repeat (5) tick();
    chk("t4_sat", 32'(glitch_cnt[15:8]), CNT_EN ? 32'd255 : 32'd0);
    repeat (5) tick();
    chk("t4_sat_hold", 32'(glitch_cnt[15:8]), CNT_EN ? 32'd255 : 32'd0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t4_clr", 32'(glitch_cnt[15:8]), 32'h0);

    // 5: clear lands on the same edge a glitch is counted.
    din[1] = 1'b1;
    tick();
    din[1] = 1'b0;
    repeat (5) tick();
    chk("t5_pre", 32'(glitch_cnt[15:8]), CNT_EN ? 32'd1 : 32'd0);
    din[1] = 1'b1;
    tick();
    din[1] = 1'b0;
    repeat (2) tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t5_collide", 32'(glitch_cnt[15:8]), 32'h0);
    tick();
    chk("t5_after", 32'(glitch_cnt[15:8]), 32'h0);

    // 6: reset while ch0 is checking a rising level.
    din[0] = 1'b1;
    repeat (3) tick();
    sys_rst = 1'b1;
    din[0]  = 1'b0;
    tick();
    sys_rst = 1'b0;
    rises = 0;
    repeat (10) tick();
    chk("t6_no_rise", 32'(rises), 32'd0);
    chk("t6_dout0", 32'(dout[0]), 32'h0);
    chk("t6_cnt", 32'(glitch_cnt), 32'h0);
    for (int i = 0; i < 12; i++) begin
      din[0] = (i < 4);
      tick();
    end
    chk("t6_accept", 32'(rises), 32'd1);

    // Random traffic with occasional clears and resets.
    repeat (3000) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(3) == 0) din[c] = ~din[c];
      end
      cnt_clr = ($urandom_range(63) == 0);
      sys_rst = ($urandom_range(999) == 0);
      tick();
    end
    sys_rst = 1'b0;
    cnt_clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
